// File: rtl/stream_accum_pkg.sv
// Shared types and widths for the stream accumulator slice.
package stream_accum_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned COUNT_W       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/term_counter.sv
// Counter of accepted nonzero terms, with synchronous clear/enable and a
// look-ahead flag that fires on the increment that reaches the limit.
module term_counter
    import stream_accum_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 255
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [COUNT_W-1:0] count_o,
    output logic               limit_hit_o
);

    localparam logic [COUNT_W-1:0] MaxCount = COUNT_W'(MAX_TERMS);

    logic [COUNT_W-1:0] count_q, count_d, count_inc;

    assign count_inc = count_q + COUNT_W'(1);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign limit_hit_o = en_i && (count_inc == MaxCount);

endmodule

// File: rtl/stream_accumulator.sv
// Sums a valid/ready stream of unsigned terms after an active-low start,
// ending on a zero sentinel or the term limit; done pulses for one cycle.
module stream_accumulator
    import stream_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_TERMS = 255
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               go_l,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [WIDTH-1:0]   sum,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic               done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   add_full;
    logic             start, nz_xfer, limit_hit;

    assign add_full = {1'b0, sum_q} + {1'b0, in_data};
    assign start    = (state_q == StIdle) && !go_l;
    assign nz_xfer  = (state_q == StAccum) && in_valid && (in_data != '0);

    term_counter #(
        .MAX_TERMS (MAX_TERMS)
    ) u_term_counter (
        .clk         (clk),
        .rst_l       (rst_l),
        .clr_i       (start),
        .en_i        (nz_xfer),
        .count_o     (count),
        .limit_hit_o (limit_hit)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (!go_l) begin
                    state_d = StAccum;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    if (in_data == '0) begin
                        state_d = StDone;
                    end else begin
                        sum_d = add_full[WIDTH-1:0];
                        ovf_d = ovf_q | add_full[WIDTH];
                        if (limit_hit) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake and done are pure state decodes so they carry no glitches.
    assign in_ready = (state_q == StAccum);
    assign done     = (state_q == StDone);
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench: runs push expected results, a monitor checks each done pulse.
module tb_stream_accumulator;

    typedef struct packed {
        logic [7:0] sum;
        logic [7:0] count;
        logic       ovf;
    } result_t;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       go_l;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] sum;
    logic [7:0] count;
    logic       overflow;
    logic       done;

    int checks   = 0;
    int failures = 0;
    result_t exp_q[$];
    logic    done_prev = 1'b0;

    always #5 clk = ~clk;

    stream_accumulator #(
        .WIDTH     (8),
        .MAX_TERMS (4)
    ) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .go_l     (go_l),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sum      (sum),
        .count    (count),
        .overflow (overflow),
        .done     (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_l && done) begin
            chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                chk("sb_sum", {24'd0, sum}, {24'd0, e.sum});
                chk("sb_count", {24'd0, count}, {24'd0, e.count});
                chk("sb_overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
        end
        done_prev <= rst_l && done;
    end

    task automatic start_run();
        @(negedge clk);
        go_l = 1'b0;
        @(negedge clk);
        go_l = 1'b1;
    endtask

    // Called at a negedge; the term transfers on the following posedge.
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        chk("ready_on_send", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic push_exp(input logic [7:0] s, input logic [7:0] c, input logic o);
        result_t e;
        e.sum   = s;
        e.count = c;
        e.ovf   = o;
        exp_q.push_back(e);
    endtask

    // At the negedge after the terminating term: done is up now, gone next cycle.
    task automatic check_done_window(input logic [7:0] s);
        chk("done_latency", {31'd0, done}, 32'd1);
        chk("ready_in_done", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("done_dropped", {31'd0, done}, 32'd0);
        chk("sum_held_idle", {24'd0, sum}, {24'd0, s});
    endtask

    initial begin
        rst_l    = 1'b0;
        go_l     = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        #12;
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_count", {24'd0, count}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // Basic sum
        push_exp(8'h0F, 8'd3, 1'b0);
        start_run();
        send(8'd3); send(8'd5); send(8'd7); send(8'd0);
        check_done_window(8'h0F);

        // Wrap, then a clean run clears the sticky overflow
        push_exp(8'h01, 8'd2, 1'b1);
        start_run();
        send(8'hFF); send(8'h02); send(8'h00);
        check_done_window(8'h01);
        push_exp(8'h01, 8'd1, 1'b0);
        start_run();
        send(8'd1); send(8'd0);
        check_done_window(8'h01);

        // Empty stream
        push_exp(8'h00, 8'd0, 1'b0);
        start_run();
        send(8'd0);
        check_done_window(8'h00);

        // Gaps in in_valid
        push_exp(8'h0A, 8'd2, 1'b0);
        start_run();
        send(8'd4);
        for (int i = 0; i < 3; i++) begin
            chk("ready_in_gap", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        send(8'd6); send(8'd0);
        check_done_window(8'h0A);

        // Term limit of 4: the fifth term must not be taken
        push_exp(8'h04, 8'd4, 1'b0);
        start_run();
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        in_valid = 1'b1;
        in_data  = 8'd9;
        chk("limit_done", {31'd0, done}, 32'd1);
        chk("limit_not_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("limit_idle_not_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'd0;
        chk("limit_sum", {24'd0, sum}, 32'd4);
        chk("limit_count", {24'd0, count}, 32'd4);

        // Reset mid-run discards the run
        start_run();
        send(8'd10); send(8'd20);
        rst_l = 1'b0;
        #1;
        chk("midrst_sum", {24'd0, sum}, 32'd0);
        chk("midrst_count", {24'd0, count}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (3) @(negedge clk);

        // go_l held low across ACCUM and DONE: ignored, then restarts in IDLE
        push_exp(8'h05, 8'd2, 1'b0);
        go_l = 1'b0;
        @(negedge clk);
        send(8'd2); send(8'd3); send(8'd0);
        chk("held_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("held_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("held_idle_sum", {24'd0, sum}, 32'd5);
        @(negedge clk);
        go_l = 1'b1;
        chk("restart_ready", {31'd0, in_ready}, 32'd1);
        chk("restart_sum_clr", {24'd0, sum}, 32'd0);
        chk("restart_count_clr", {24'd0, count}, 32'd0);
        push_exp(8'h00, 8'd0, 1'b0);
        send(8'd0);
        check_done_window(8'h00);

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
